// File: rtl/adc128s_spi_model_pkg.sv
// Shared constants for the ADC128S-style SPI converter model: channel codes,
// frame length and the position of the channel-select field in a command word.
package adc128s_pkg;

  localparam int DATA_W     = 12;
  localparam int FRAME_BITS = 16;

  localparam logic [2:0] CH_LD_LFT  = 3'd0;
  localparam logic [2:0] CH_LD_RGHT = 3'd4;
  localparam logic [2:0] CH_STEER   = 3'd5;
  localparam logic [2:0] CH_BATT    = 3'd6;

  localparam int CH_SEL_MSB = 13;
  localparam int CH_SEL_LSB = 11;

  // Extracts the channel address the master sent; the other command bits are ignored.
  function automatic logic [2:0] cmd_chan(input logic [FRAME_BITS-1:0] word);
    return word[CH_SEL_MSB:CH_SEL_LSB];
  endfunction

endpackage

// File: rtl/adc128s_spi_model_if.sv
// SPI bus between the A2D master and the converter model.
interface adc128s_spi_model_if;
  logic SS_n;
  logic SCLK;
  logic MOSI;
  logic MISO;

  modport master (output SS_n, output SCLK, output MOSI, input MISO);
  modport slave  (input SS_n, input SCLK, input MOSI, output MISO);
endinterface

// File: rtl/adc128s_spi_model_spi_slave_sync_shift.sv
// SPI slave front end: clk-domain synchronisers, SCLK/SS_n edge detection,
// bit counter and the receive/transmit shift registers.
module spi_slave_sync_shift #(
  parameter int FRAME_BITS = 16,
  parameter int CNT_W      = $clog2(FRAME_BITS + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ss_n_i,
  input  logic                  sclk_i,
  input  logic                  mosi_i,
  input  logic [FRAME_BITS-1:0] load_i,
  output logic                  frame_start_o,
  output logic                  frame_done_o,
  output logic [FRAME_BITS-1:0] rx_word_o,
  output logic                  miso_o
);

  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FRAME_BITS);

  logic [2:0]            ss_sync_q;
  logic [2:0]            sclk_sync_q;
  logic [1:0]            mosi_sync_q;
  logic [CNT_W-1:0]      bit_cnt_q, bit_cnt_d;
  logic [FRAME_BITS-1:0] rx_q, rx_d;
  logic [FRAME_BITS-1:0] tx_q, tx_d;
  logic                  miso_q, miso_d;

  logic ss_n_s, ss_fall, ss_rise, sclk_rise, sclk_fall, mosi_s;

  // Bit 1 of each chain is the synchronised level, bit 2 the previous one.
  assign ss_n_s    = ss_sync_q[1];
  assign ss_fall   = ss_sync_q[2] & ~ss_sync_q[1];
  assign ss_rise   = ~ss_sync_q[2] & ss_sync_q[1];
  assign sclk_rise = ~sclk_sync_q[2] & sclk_sync_q[1];
  assign sclk_fall = sclk_sync_q[2] & ~sclk_sync_q[1];
  assign mosi_s    = mosi_sync_q[1];

  always_comb begin
    bit_cnt_d = bit_cnt_q;
    rx_d      = rx_q;
    tx_d      = tx_q;
    miso_d    = miso_q;
    if (ss_fall) begin
      bit_cnt_d = '0;
      tx_d      = load_i;
      miso_d    = load_i[FRAME_BITS-1];
    end else if (!ss_n_s) begin
      if (sclk_rise && (bit_cnt_q < FULL_CNT)) begin
        rx_d      = {rx_q[FRAME_BITS-2:0], mosi_s};
        bit_cnt_d = bit_cnt_q + 1'b1;
      end
      // The leading fall of a frame precedes the first sample and must not shift.
      if (sclk_fall && (bit_cnt_q != '0)) begin
        tx_d   = {tx_q[FRAME_BITS-2:0], 1'b0};
        miso_d = tx_q[FRAME_BITS-2];
      end
    end else begin
      miso_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ss_sync_q   <= 3'b111;
      sclk_sync_q <= 3'b111;
      mosi_sync_q <= 2'b00;
      bit_cnt_q   <= '0;
      rx_q        <= '0;
      tx_q        <= '0;
      miso_q      <= 1'b0;
    end else begin
      ss_sync_q   <= {ss_sync_q[1:0], ss_n_i};
      sclk_sync_q <= {sclk_sync_q[1:0], sclk_i};
      mosi_sync_q <= {mosi_sync_q[0], mosi_i};
      bit_cnt_q   <= bit_cnt_d;
      rx_q        <= rx_d;
      tx_q        <= tx_d;
      miso_q      <= miso_d;
    end
  end

  assign frame_start_o = ss_fall;
  assign frame_done_o  = ss_rise && (bit_cnt_q == FULL_CNT);
  assign rx_word_o     = rx_q;
  assign miso_o        = miso_q;

endmodule

// File: rtl/adc128s_spi_model.sv
// ADC128S-style converter model: each complete frame selects the channel that
// the following frame returns; partial frames leave the selection alone.
module adc128s_spi_model #(
  parameter int DATA_W     = adc128s_pkg::DATA_W,
  parameter int FRAME_BITS = adc128s_pkg::FRAME_BITS
) (
  input  logic                clk,
  input  logic                rst,
  adc128s_spi_model_if.slave  spi,
  input  logic [DATA_W-1:0]   ld_cell_lft,
  input  logic [DATA_W-1:0]   ld_cell_rght,
  input  logic [DATA_W-1:0]   steerPot,
  input  logic [DATA_W-1:0]   batt
);
  import adc128s_pkg::*;

  logic [2:0]            chan_ptr_q, chan_ptr_d;
  logic [DATA_W-1:0]     chan_val;
  logic [FRAME_BITS-1:0] load;
  logic                  frame_start, frame_done, miso;
  logic [FRAME_BITS-1:0] rx_word;

  always_comb begin
    chan_val = '0;
    case (chan_ptr_q)
      CH_LD_LFT:  chan_val = ld_cell_lft;
      CH_LD_RGHT: chan_val = ld_cell_rght;
      CH_STEER:   chan_val = steerPot;
      CH_BATT:    chan_val = batt;
      default:    chan_val = '0;
    endcase
  end

  // Only the value presented on the frame-start cycle is captured by the shifter.
  assign load = frame_start ? {{(FRAME_BITS-DATA_W){1'b0}}, chan_val} : '0;

  always_comb begin
    chan_ptr_d = chan_ptr_q;
    if (frame_done) chan_ptr_d = cmd_chan(rx_word);
  end

  always_ff @(posedge clk) begin
    if (rst) chan_ptr_q <= CH_LD_LFT;
    else     chan_ptr_q <= chan_ptr_d;
  end

  spi_slave_sync_shift #(.FRAME_BITS(FRAME_BITS)) u_sync_shift (
    .clk           (clk),
    .rst           (rst),
    .ss_n_i        (spi.SS_n),
    .sclk_i        (spi.SCLK),
    .mosi_i        (spi.MOSI),
    .load_i        (load),
    .frame_start_o (frame_start),
    .frame_done_o  (frame_done),
    .rx_word_o     (rx_word),
    .miso_o        (miso)
  );

  assign spi.MISO = miso;

endmodule

// File: tb/tb_adc128s_spi_model.sv
// Bench for adc128s_spi_model: an SPI master task queues the word each full
// frame should return; an independent bus monitor assembles MISO and compares.
module tb_adc128s_spi_model;

  localparam int HALF = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [11:0] lft = '0, rght = '0, steer = '0, batt = '0;

  adc128s_spi_model_if spi ();

  adc128s_spi_model dut (
    .clk          (clk),
    .rst          (rst),
    .spi          (spi.slave),
    .ld_cell_lft  (lft),
    .ld_cell_rght (rght),
    .steerPot     (steer),
    .batt         (batt)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          failures = 0;
  logic [15:0] exp_q[$];
  int          model_chan = 0;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  function automatic logic [15:0] ref_word(input int ch);
    case (ch)
      0:       return {4'h0, lft};
      4:       return {4'h0, rght};
      5:       return {4'h0, steer};
      6:       return {4'h0, batt};
      default: return 16'h0000;
    endcase
  endfunction

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  // nrise < 16 aborts the frame; batt_rise >= 0 changes batt after that rise;
  // rst_rise >= 0 pulses reset mid-frame after that rise.
  task automatic frame(input logic [15:0] cmd, input int nrise,
                       input int batt_rise, input logic [11:0] batt_new,
                       input int rst_rise);
    @(negedge clk);
    if (nrise == 16 && rst_rise < 0) exp_q.push_back(ref_word(model_chan));
    spi.SS_n = 1'b0;
    wait_clk(HALF);
    spi.SCLK = 1'b0;
    for (int i = 0; i < nrise; i++) begin
      spi.MOSI = cmd[15-i];
      wait_clk(HALF);
      spi.SCLK = 1'b1;
      wait_clk(HALF);
      if (i == batt_rise) batt = batt_new;
      if (i == rst_rise) begin
        rst = 1'b1;
        wait_clk(4);
        check("miso_in_reset", {15'd0, spi.MISO}, 16'h0000);
        spi.SS_n = 1'b1;
        wait_clk(4);
        rst = 1'b0;
        model_chan = 0;
        wait_clk(HALF);
        return;
      end
      if (i < nrise - 1) spi.SCLK = 1'b0;
    end
    spi.SCLK = 1'b1;
    wait_clk(HALF);
    spi.SS_n = 1'b1;
    wait_clk(2 * HALF);
    if (nrise == 16) model_chan = int'(cmd[13:11]);
  endtask

  // Bus monitor: samples MISO on every SCLK rise inside a frame.
  int          mon_cnt = 0;
  logic [15:0] mon_word = '0;

  initial forever begin
    @(negedge spi.SS_n);
    mon_cnt  = 0;
    mon_word = '0;
  end

  initial forever begin
    @(posedge spi.SCLK);
    if (spi.SS_n === 1'b0 && rst === 1'b0) begin
      mon_word = {mon_word[14:0], spi.MISO};
      mon_cnt++;
    end
  end

  initial forever begin
    @(posedge spi.SS_n);
    if (mon_cnt == 16) begin
      if (exp_q.size() == 0) begin
        check("unexpected_frame", mon_word, 16'hxxxx);
      end else begin
        check("frame_word", mon_word, exp_q.pop_front());
      end
    end
    mon_cnt = 0;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    spi.SS_n = 1'b1;
    spi.SCLK = 1'b1;
    spi.MOSI = 1'b0;
    wait_clk(5);
    check("miso_after_reset", {15'd0, spi.MISO}, 16'h0000);
    rst = 1'b0;
    wait_clk(5);
    check("miso_idle", {15'd0, spi.MISO}, 16'h0000);

    lft = 12'h123;
    frame(16'h0000, 16, -1, '0, -1);
    frame(16'h2800, 16, -1, '0, -1);
    steer = 12'hA5C;
    frame(16'h0000, 16, -1, '0, -1);

    rght = 12'h3FF; batt = 12'hC00; lft = 12'h001;
    frame(16'h2000, 16, -1, '0, -1);
    frame(16'h3000, 16, -1, '0, -1);
    frame(16'h0000, 16, -1, '0, -1);
    frame(16'h1800, 16, -1, '0, -1);
    frame(16'h3000, 16, -1, '0, -1);
    batt = 12'h800;
    frame(16'h0000, 16, 5, 12'h900, -1);

    frame(16'h3000, 8, -1, '0, -1);
    frame(16'h0000, 16, -1, '0, -1);

    frame(16'h2800, 16, -1, '0, -1);
    frame(16'h3000, 16, -1, '0, 7);
    frame(16'h0000, 16, -1, '0, -1);

    for (int n = 0; n < 24; n++) begin
      lft   = 12'($urandom);
      rght  = 12'($urandom);
      steer = 12'($urandom);
      batt  = 12'($urandom);
      frame(16'($urandom), ($urandom_range(0, 4) == 0) ? $urandom_range(1, 15) : 16, -1, '0, -1);
    end

    wait_clk(20);
    check("queue_drained", 16'(exp_q.size()), 16'h0000);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
